// File: rtl/ofifo_param.sv
// Output FIFO of COL independently written columns read out as whole rows; optional o_occupancy under OFIFO_PARAM_OCC_EN.
// Latency: a row is readable once its last column is written; out/o_out_valid follow an accepted read by one cycle.
// Backpressure: a write to a full column is dropped and sets sticky o_overflow; rd is ignored while o_valid is low.
module ofifo_param #(
    parameter int COL   = 8,
    parameter int BW    = 4,
    parameter int DEPTH = 64,
    parameter int AF_TH = DEPTH - 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BW*COL-1:0]    in,
    input  logic [COL-1:0]       wr,
    input  logic                 rd,
    output logic [BW*COL-1:0]    out,
    output logic                 o_out_valid,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_ready,
    output logic                 o_almost_full,
    output logic                 o_overflow
`ifdef OFIFO_PARAM_OCC_EN
    ,
    output logic [$clog2(DEPTH):0] o_occupancy
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [BW-1:0] mem [COL][DEPTH];
    logic [AW-1:0] wp  [COL];
    logic [CW-1:0] cnt [COL];
    logic [AW-1:0] rp;

    logic [COL-1:0] col_full;
    logic [COL-1:0] col_empty;
    logic [COL-1:0] col_af;
    logic [COL-1:0] wr_acc;
    logic           rd_acc;

    always_comb begin
        col_full  = '0;
        col_empty = '0;
        col_af    = '0;
        wr_acc    = '0;
        for (int i = 0; i < COL; i++) begin
            col_full[i]  = (cnt[i] == CW'(DEPTH));
            col_empty[i] = (cnt[i] == '0);
            col_af[i]    = (cnt[i] >= CW'(AF_TH));
            wr_acc[i]    = wr[i] & ~col_full[i];
        end
    end

    assign o_valid       = ~|col_empty;
    assign o_full        = |col_full;
    assign o_ready       = ~o_full;
    assign o_almost_full = |col_af;
    assign rd_acc        = rd & o_valid;

    // Storage is not reset; counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < COL; i++) begin
                if (wr_acc[i]) begin
                    mem[i][wp[i]] <= in[i*BW +: BW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < COL; i++) begin
                wp[i]  <= '0;
                cnt[i] <= '0;
            end
            rp          <= '0;
            out         <= '0;
            o_out_valid <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < COL; i++) begin
                if (wr_acc[i]) begin
                    wp[i] <= wp[i] + AW'(1);
                end
                cnt[i] <= cnt[i] + CW'(wr_acc[i]) - CW'(rd_acc);
            end
            if (rd_acc) begin
                rp <= rp + AW'(1);
                for (int i = 0; i < COL; i++) begin
                    out[i*BW +: BW] <= mem[i][rp];
                end
            end
            o_out_valid <= rd_acc;
            // A full column drops its write even when a read frees space on the same edge.
            if (|(wr & col_full)) begin
                o_overflow <= 1'b1;
            end
        end
    end

`ifdef OFIFO_PARAM_OCC_EN
    logic [CW-1:0] occ_min;

    always_comb begin
        occ_min = cnt[0];
        for (int i = 1; i < COL; i++) begin
            if (cnt[i] < occ_min) begin
                occ_min = cnt[i];
            end
        end
    end

    assign o_occupancy = occ_min;
`endif

endmodule

// File: tb/tb_ofifo_param.sv
// Scoreboard bench for ofifo_param: rows pushed when their last column is written, popped when out is valid.
module tb_ofifo_param;

    localparam int COL   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int AF_TH = 60;
    localparam int W     = BW * COL;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in;
    logic [COL-1:0] wr;
    logic          rd;
    logic [W-1:0]  out;
    logic          o_out_valid, o_valid, o_full, o_ready, o_almost_full, o_overflow;
`ifdef OFIFO_PARAM_OCC_EN
    logic [$clog2(DEPTH):0] o_occupancy;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] exp_row;
    logic [W-1:0] x;

    ofifo_param #(.COL(COL), .BW(BW), .DEPTH(DEPTH), .AF_TH(AF_TH)) dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .wr           (wr),
        .rd           (rd),
        .out          (out),
        .o_out_valid  (o_out_valid),
        .o_valid      (o_valid),
        .o_full       (o_full),
        .o_ready      (o_ready),
        .o_almost_full(o_almost_full),
        .o_overflow   (o_overflow)
`ifdef OFIFO_PARAM_OCC_EN
        ,
        .o_occupancy  (o_occupancy)
`endif
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
    endtask

    // Pops the scoreboard and compares one read result.
    task automatic check_pop_row(input string tag);
        n_cmp++;
        if (o_out_valid !== 1'b1) begin
            n_bad++; $display("FAIL %s_ovld: got %b want 1", tag, o_out_valid);
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++; $display("FAIL %s_sb: out=%h with no expected row", tag, out);
        end else begin
            exp_row = sb.pop_front();
            if (out !== exp_row) begin
                n_bad++; $display("FAIL %s_out: got %h want %h", tag, out, exp_row);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b want 0", o_full); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_almost_full !== 1'b0) begin n_bad++; $display("FAIL rst_af: got %b want 0", o_almost_full); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", o_overflow); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_ovld: got %b want 0", o_out_valid); end
        n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL rst_out: got %h want 0", out); end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wr = 8'hFF; in = 32'h76543210; sb.push_back(32'h76543210);
        end
        @(negedge clk);
        wr = '0; rd = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_pop_row("basic");
        end
        rd = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL basic_empty: got %b want 0", o_valid); end
        @(negedge clk);
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ovld_drop: got %b want 0", o_out_valid); end
        n_cmp++; if (out !== 32'h76543210) begin n_bad++; $display("FAIL basic_hold: got %h want 76543210", out); end
    endtask

    task automatic test_partial();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr = 8'h01; rd = 1'b1; in = 32'hFFFFFFF0 | (i + 1);
            @(negedge clk);
            wr = '0;
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL part_valid%0d: got %b want 0", i, o_valid); end
            n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL part_ovld%0d: got %b want 0", i, o_out_valid); end
        end
        rd = 1'b0; wr = 8'hFE; in = 32'h9ABCDEF0; sb.push_back(32'h9ABCDEF1);
        @(negedge clk);
        wr = '0;
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL part_valid_done: got %b want 1", o_valid); end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check_pop_row("part");
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            wr = 8'h01; in = {28'h0, 4'(i)};
        end
        @(negedge clk);
        wr = 8'h01; in = 32'h0000000F;
        n_cmp++; if (o_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full64: got %b want 1", o_full); end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_early: got %b want 0", o_overflow); end
        @(negedge clk);
        wr = '0;
        n_cmp++; if (o_full !== 1'b1) begin n_bad++; $display("FAIL ovf_full: got %b want 1", o_full); end
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_ready: got %b want 0", o_ready); end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", o_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            x = $urandom; x[3:0] = 4'hF;
            wr = 8'hFE; in = x; sb.push_back({x[31:4], 4'(i)});
        end
        @(negedge clk);
        wr = '0; rd = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (i == DEPTH - 1) rd = 1'b0;
            check_pop_row("ovf");
        end
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", o_valid); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL ovf_unfull: got %b want 0", o_full); end
        n_cmp++; if (o_overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow); end
    endtask

    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < AF_TH; i++) begin
            @(negedge clk);
            x = $urandom;
            wr = 8'hFF; in = x; sb.push_back(x);
            @(negedge clk);
            wr = '0;
            n_cmp++;
            if (o_almost_full !== ((i + 1) >= AF_TH)) begin
                n_bad++; $display("FAIL af_rows%0d: got %b want %b", i + 1, o_almost_full, (i + 1) >= AF_TH);
            end
        end
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        check_pop_row("af");
        n_cmp++; if (o_almost_full !== 1'b0) begin n_bad++; $display("FAIL af_after_rd: got %b want 0", o_almost_full); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            x = $urandom; wr = 8'hFF; in = x; sb.push_back(x);
        end
        for (int k = 0; k <= 200; k++) begin
            @(negedge clk);
            if (k > 0) begin
                check_pop_row("stream");
                n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid%0d: got %b want 1", k, o_valid); end
`ifdef OFIFO_PARAM_OCC_EN
                n_cmp++; if (o_occupancy !== 7'd2) begin n_bad++; $display("FAIL stream_occ%0d: got %0d want 2", k, o_occupancy); end
`endif
            end
            if (k < 200) begin
                x = $urandom; wr = 8'hFF; rd = 1'b1; in = x; sb.push_back(x);
            end else begin
                wr = '0; rd = 1'b0;
            end
        end
        n_cmp++; if (o_overflow !== 1'b0) begin n_bad++; $display("FAIL stream_ovf: got %b want 0", o_overflow); end
        n_cmp++; if (o_full !== 1'b0) begin n_bad++; $display("FAIL stream_full: got %b want 0", o_full); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            x = $urandom; wr = 8'hFF; in = x;
        end
        @(negedge clk);
        wr = '0; rd = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_ovld: got %b want 1", o_out_valid); end
        reset = 1'b0; wr = 8'hFF; rd = 1'b1;
        @(negedge clk);
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_ovld: got %b want 0", o_out_valid); end
        n_cmp++; if (out !== '0) begin n_bad++; $display("FAIL mid_out: got %h want 0", out); end
`ifdef OFIFO_PARAM_OCC_EN
        n_cmp++; if (o_occupancy !== '0) begin n_bad++; $display("FAIL mid_occ: got %0d want 0", o_occupancy); end
`endif
        reset = 1'b1; wr = '0; rd = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        test_reset();
        test_basic();
        test_partial();
        test_overflow();
        test_almost_full();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ofifo_param.md
OFIFO_PARAM -- requirements
Module: ofifo_param

Interface
REQ-001 SHALL provide parameter COL, default 8: number of independent write columns.
REQ-002 SHALL provide parameter BW, default 4: bits per column entry.
REQ-003 SHALL provide parameter DEPTH, default 64: entries per column; power of two, minimum 4.
REQ-004 SHALL provide parameter AF_TH, default DEPTH-4: almost-full threshold in entries, range 1..DEPTH.
REQ-005 SHALL have port: clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 SHALL have port: reset  input  1  reset, synchronous, active-low (0 = reset).
REQ-007 SHALL have port: in  input  BW*COL  column i data at bits [(i+1)*BW-1 : i*BW].
REQ-008 SHALL have port: wr  input  COL  per-column write strobe.
REQ-009 SHALL have port: rd  input  1  row read request.
REQ-010 SHALL have port: out  output  BW*COL  registered read row, same column packing as in.
REQ-011 SHALL have port: o_out_valid  output  1  out carries a newly popped row this cycle.
REQ-012 SHALL have port: o_valid  output  1  at least one complete row is stored.
REQ-013 SHALL have port: o_full  output  1  at least one column is full.
REQ-014 SHALL have port: o_ready  output  1  equals ~o_full.
REQ-015 SHALL have port: o_almost_full  output  1  at least one column holds AF_TH or more entries.
REQ-016 SHALL have port: o_overflow  output  1  sticky flag; a write was dropped.

Function
REQ-017 SHALL keep per column i:
- a DEPTH-entry circular store
- a write pointer wp[i] (log2(DEPTH) bits)
- a count cnt[i] (log2(DEPTH)+1 bits).
REQ-018 SHALL use one shared read pointer rp for all columns; a row is entry rp of every column.
REQ-019 SHALL accept a write when wr[i]=1 and cnt[i]<DEPTH before the edge:
- in slice i is stored at wp[i]
- wp[i] increments modulo DEPTH (wraps DEPTH-1 -> 0).
REQ-020 SHALL drop a write when wr[i]=1 and cnt[i]==DEPTH before the edge, even if a read is accepted in the same cycle; o_overflow SHALL then be set to 1 on that edge.
REQ-021 SHALL drive o_valid = 1 iff every cnt[i] is nonzero; combinational from registered counts.
REQ-022 SHALL drive o_full = 1 iff any cnt[i]==DEPTH, and o_almost_full = 1 iff any cnt[i]>=AF_TH.
REQ-023 SHALL accept a read when rd=1 and o_valid=1 at the edge:
- out is loaded with the row at rp
- rp increments modulo DEPTH
- every cnt[i] decrements.
REQ-024 SHALL assert o_out_valid for exactly one cycle following each accepted read (one-cycle read latency); out SHALL hold its last value otherwise.
REQ-025 SHALL ignore rd when o_valid=0: no pointer, count or output change; o_out_valid = 0.
REQ-026 SHALL, when a write to column i and an accepted read occur on the same edge, perform both and leave cnt[i] unchanged.
REQ-027 SHALL sustain one accepted read per cycle indefinitely while o_valid stays 1.
REQ-028 SHALL allow columns to be written independently at different rates; a row becomes readable only once its last column has been written.

Reset
REQ-029 SHALL, when reset=0 at a clk edge, clear all wp, rp, cnt, out, o_out_valid and o_overflow to 0; stored data is discarded.
REQ-030 SHALL give reset priority over wr and rd on the same edge, including mid-stream.
REQ-031 SHALL present after reset: o_valid=0, o_full=0, o_ready=1, o_almost_full=0.

Configuration
REQ-032 SHALL, with macro OFIFO_PARAM_OCC_EN defined, add output port o_occupancy (log2(DEPTH)+1 bits):
- value is the minimum cnt[i] over all columns, i.e. complete stored rows
- combinational from registered counts
- 0 after reset.
REQ-033 SHALL, without OFIFO_PARAM_OCC_EN, omit the o_occupancy port and its minimum logic; all other behaviour is identical.

Verification
REQ-034 SHALL cover: COL=8, BW=4, DEPTH=64; write all columns with in=32'h76543210 for 3 cycles, then rd=1 for 3 cycles -> o_out_valid high on 3 consecutive cycles, each one cycle after read acceptance, out=32'h76543210 each time, then o_valid=0.
REQ-035 SHALL cover: wr=8'h01 only, 5 cycles -> o_valid stays 0 and rd has no effect; then wr=8'hFE once -> o_valid=1.
REQ-036 SHALL cover: fill column 0 with 64 writes, then write a 65th -> o_full=1, o_ready=0, o_overflow=1; the dropped value never appears on out.
REQ-037 SHALL cover: 60 rows written with AF_TH=60 -> o_almost_full=1; one read -> o_almost_full=0.
REQ-038 SHALL cover: 200 rows streamed with simultaneous wr=8'hFF and rd=1 -> in-order data across pointer wrap, counts constant, no overflow.
REQ-039 SHALL cover: reset=0 asserted with 10 rows stored and rd=1 -> next cycle o_valid=0, o_out_valid=0, out=0, o_occupancy=0 (macro defined).
